// File: rtl/fifo_drain_66to33_if.sv
// Handshake bundle between an upstream show-ahead FIFO, the 66-to-33 drain and its sink.
// The master side is the environment (FIFO and sink); the slave side is the drain itself.
interface fifo_drain_66to33_if #(
    parameter int unsigned DATA_W = 66,
    parameter int unsigned HALF_W = DATA_W / 2
);
    logic              fifo_empty_i;
    logic [DATA_W-1:0] fifo_rdata_i;
    logic              fifo_rden_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [HALF_W-1:0] out_data_o;
    logic              out_last_o;
    logic              hdr_err_o;
    logic [7:0]        hdr_err_cnt_o;

    modport slave (
        input  fifo_empty_i,
        input  fifo_rdata_i,
        input  out_ready_i,
        output fifo_rden_o,
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        output hdr_err_o,
        output hdr_err_cnt_o
    );

    modport master (
        output fifo_empty_i,
        output fifo_rdata_i,
        output out_ready_i,
        input  fifo_rden_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        input  hdr_err_o,
        input  hdr_err_cnt_o
    );
endinterface

// File: rtl/fifo_drain_66to33.sv
// Drains DATA_W-bit words from a show-ahead FIFO and emits each as two HALF_W-bit beats,
// high half first, with last marking the low half. Full throughput: one beat per cycle.
// Optional sync-header check (top two bits 00/11 flagged) under FIFO_DRAIN_HDR_CHECK_EN.
module fifo_drain_66to33 #(
    parameter int unsigned DATA_W = 66,
    parameter int unsigned HALF_W = DATA_W / 2
) (
    input logic                   clk,
    input logic                   reset,
    fifo_drain_66to33_if.slave    bus_io
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StBeatHi = 2'd1,
        StBeatLo = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              pop;

    // Pop decision and next-state; pop is gated by reset so nothing is lost during reset.
    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        hold_d  = hold_q;
        if (!reset && !bus_io.fifo_empty_i) begin
            pop = (state_q == StIdle) || ((state_q == StBeatLo) && bus_io.out_ready_i);
        end
        if (pop) begin
            hold_d = bus_io.fifo_rdata_i;
        end
        unique case (state_q)
            StIdle: begin
                if (pop) state_d = StBeatHi;
            end
            StBeatHi: begin
                if (bus_io.out_ready_i) state_d = StBeatLo;
            end
            StBeatLo: begin
                if (bus_io.out_ready_i) state_d = pop ? StBeatHi : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Output beat selection; data is zero while idle.
    always_comb begin
        bus_io.fifo_rden_o = pop;
        bus_io.out_valid_o = 1'b0;
        bus_io.out_last_o  = 1'b0;
        bus_io.out_data_o  = '0;
        unique case (state_q)
            StBeatHi: begin
                bus_io.out_valid_o = 1'b1;
                bus_io.out_data_o  = hold_q[DATA_W-1:HALF_W];
            end
            StBeatLo: begin
                bus_io.out_valid_o = 1'b1;
                bus_io.out_last_o  = 1'b1;
                bus_io.out_data_o  = hold_q[HALF_W-1:0];
            end
            default: ;
        endcase
    end

`ifdef FIFO_DRAIN_HDR_CHECK_EN
    logic       hdr_bad;
    logic       hdr_err_q, hdr_err_d;
    logic [7:0] hdr_cnt_q, hdr_cnt_d;

    // Valid sync headers are 01 and 10; the pulse lands on the first high-beat cycle.
    always_comb begin
        hdr_bad   = bus_io.fifo_rdata_i[DATA_W-1] == bus_io.fifo_rdata_i[DATA_W-2];
        hdr_err_d = pop && hdr_bad;
        hdr_cnt_d = hdr_cnt_q;
        if (hdr_err_d && (hdr_cnt_q != 8'hFF)) begin
            hdr_cnt_d = hdr_cnt_q + 8'd1;
        end
    end

    // Header error pulse and saturating count.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_err_q <= 1'b0;
            hdr_cnt_q <= 8'd0;
        end else begin
            hdr_err_q <= hdr_err_d;
            hdr_cnt_q <= hdr_cnt_d;
        end
    end

    assign bus_io.hdr_err_o     = hdr_err_q;
    assign bus_io.hdr_err_cnt_o = hdr_cnt_q;
`else
    assign bus_io.hdr_err_o     = 1'b0;
    assign bus_io.hdr_err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_drain_66to33.sv
// Directed bench for fifo_drain_66to33: a queue models the show-ahead FIFO, expectations
// are hand-computed per step. Header-check expectations follow FIFO_DRAIN_HDR_CHECK_EN.
module tb_fifo_drain_66to33;

    localparam int unsigned DW = 66;
    localparam int unsigned HW = 33;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_drain_66to33_if #(.DATA_W(DW)) bus ();

    fifo_drain_66to33 #(.DATA_W(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    logic [DW-1:0] q[$];
    int vecs = 0;
    int errs = 0;

    task automatic drive_fifo();
        bus.fifo_empty_i = (q.size() == 0);
        bus.fifo_rdata_i = (q.size() == 0) ? '0 : q[0];
    endtask

    // Advance one clock; the new cycle's ready/reset take effect after the edge.
    task automatic tick(input logic rdy, input logic rst);
        logic rd;
        rd = bus.fifo_rden_o;
        @(posedge clk);
        #1;
        if (rd === 1'b1) void'(q.pop_front());
        drive_fifo();
        bus.out_ready_i = rdy;
        reset = rst;
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic v, input logic l,
                        input logic [HW-1:0] d, input logic r);
        chk({tag, ".valid"}, DW'(bus.out_valid_o), DW'(v));
        chk({tag, ".last"},  DW'(bus.out_last_o),  DW'(l));
        chk({tag, ".data"},  DW'(bus.out_data_o),  DW'(d));
        chk({tag, ".rden"},  DW'(bus.fifo_rden_o), DW'(r));
    endtask

    function automatic logic [HW-1:0] hi(input logic [DW-1:0] w);
        return w[DW-1:HW];
    endfunction

    function automatic logic [HW-1:0] lo(input logic [DW-1:0] w);
        return w[HW-1:0];
    endfunction

    initial begin
        logic [DW-1:0] w, wa, wb;
        logic [1:0]    hdr;
        logic          bad;
        int            exp_cnt;

        reset = 1'b1;
        bus.out_ready_i = 1'b1;
        drive_fifo();
        #1;

        // Reset: a waiting word must not be popped while reset is high.
        q.push_back(66'h1_0123_4567_89AB_CDEF);
        drive_fifo();
        tick(1'b1, 1'b1);
        chk("rst_rden", DW'(bus.fifo_rden_o), '0);
        tick(1'b1, 1'b0);
        beat("rst_out", 1'b0, 1'b0, '0, 1'b1);
        chk("rst_hdr_err", DW'(bus.hdr_err_o), '0);
        chk("rst_hdr_cnt", DW'(bus.hdr_err_cnt_o), '0);

        // Single word: hi = w[65:33], lo = w[32:0].
        tick(1'b1, 1'b0);
        beat("single_hi", 1'b1, 1'b0, 33'h0_8091_A2B3, 1'b0);
        tick(1'b1, 1'b0);
        beat("single_lo", 1'b1, 1'b1, 33'h1_89AB_CDEF, 1'b0);
        tick(1'b1, 1'b0);
        beat("single_idle", 1'b0, 1'b0, '0, 1'b0);

        // Streaming: 8 words, 16 back-to-back beats, pop on every low beat but the final one.
        for (int i = 0; i < 8; i++) q.push_back({2'b01, 32'hC0DE_0000 + i, 32'h1234_5600 + i});
        drive_fifo();
        #1;
        chk("stream_first_rden", DW'(bus.fifo_rden_o), DW'(1));
        for (int k = 0; k < 16; k++) begin
            w = {2'b01, 32'hC0DE_0000 + (k / 2), 32'h1234_5600 + (k / 2)};
            tick(1'b1, 1'b0);
            beat($sformatf("stream%0d", k), 1'b1, k[0], k[0] ? lo(w) : hi(w),
                 k[0] && (k != 15));
        end
        tick(1'b1, 1'b0);
        beat("stream_idle", 1'b0, 1'b0, '0, 1'b0);

        // Backpressure in both beats, then empty boundary.
        wa = {2'b10, 64'hDEAD_BEEF_0BAD_F00D};
        wb = {2'b01, 64'h0123_0000_FFFF_5555};
        q.push_back(wa);
        q.push_back(wb);
        drive_fifo();
        #1;
        chk("bp_rden", DW'(bus.fifo_rden_o), DW'(1));
        tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            beat($sformatf("bp_hi%0d", i), 1'b1, 1'b0, hi(wa), 1'b0);
            tick((i == 4), 1'b0);
        end
        beat("bp_hi_acc", 1'b1, 1'b0, hi(wa), 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            beat($sformatf("bp_lo%0d", i), 1'b1, 1'b1, lo(wa), 1'b0);
            tick((i == 4), 1'b0);
        end
        beat("bp_lo_acc", 1'b1, 1'b1, lo(wa), 1'b1);
        tick(1'b1, 1'b0);
        beat("bp_b_hi", 1'b1, 1'b0, hi(wb), 1'b0);
        tick(1'b1, 1'b0);
        beat("bp_b_lo", 1'b1, 1'b1, lo(wb), 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(i[0], 1'b0);
            beat($sformatf("empty_idle%0d", i), 1'b0, 1'b0, '0, 1'b0);
        end
        w = {2'b10, 64'h5A5A_A5A5_1111_2222};
        q.push_back(w);
        drive_fifo();
        #1;
        chk("late_rden", DW'(bus.fifo_rden_o), DW'(1));
        tick(1'b1, 1'b0);
        beat("late_hi", 1'b1, 1'b0, hi(w), 1'b0);
        tick(1'b1, 1'b0);
        beat("late_lo", 1'b1, 1'b1, lo(w), 1'b0);
        tick(1'b1, 1'b0);

        // Reset during the low beat drops the rest of that word.
        wa = {2'b01, 64'hAAAA_BBBB_CCCC_DDDD};
        wb = {2'b10, 64'h1357_9BDF_2468_ACE0};
        q.push_back(wa);
        q.push_back(wb);
        drive_fifo();
        #1;
        tick(1'b1, 1'b0);
        beat("mid_hi", 1'b1, 1'b0, hi(wa), 1'b0);
        tick(1'b1, 1'b1);
        chk("mid_rst_rden", DW'(bus.fifo_rden_o), '0);
        tick(1'b1, 1'b0);
        beat("mid_after", 1'b0, 1'b0, '0, 1'b1);
        tick(1'b1, 1'b0);
        beat("mid_next_hi", 1'b1, 1'b0, hi(wb), 1'b0);
        tick(1'b1, 1'b0);
        beat("mid_next_lo", 1'b1, 1'b1, lo(wb), 1'b0);
        tick(1'b1, 1'b0);

        // Sync-header check: 00, 01, 11, 10, then 300 words of 00.
        for (int i = 0; i < 304; i++) begin
            case (i)
                1:       hdr = 2'b01;
                2:       hdr = 2'b11;
                3:       hdr = 2'b10;
                default: hdr = 2'b00;
            endcase
            q.push_back({hdr, 64'(i)});
        end
        drive_fifo();
        #1;
        exp_cnt = 0;
        for (int i = 0; i < 304; i++) begin
            tick(1'b1, 1'b0);
            bad = (i != 1) && (i != 3);
`ifdef FIFO_DRAIN_HDR_CHECK_EN
            if (bad && exp_cnt < 255) exp_cnt++;
`else
            bad = 1'b0;
`endif
            chk($sformatf("hdr%0d_err", i), DW'(bus.hdr_err_o), DW'(bad));
            chk($sformatf("hdr%0d_cnt", i), DW'(bus.hdr_err_cnt_o), DW'(exp_cnt));
            tick(1'b1, 1'b0);
            chk($sformatf("hdr%0d_lo_err", i), DW'(bus.hdr_err_o), '0);
        end
`ifdef FIFO_DRAIN_HDR_CHECK_EN
        chk("hdr_cnt_final", DW'(bus.hdr_err_cnt_o), DW'(255));
`else
        chk("hdr_cnt_final", DW'(bus.hdr_err_cnt_o), '0);
`endif
        tick(1'b1, 1'b0);
        beat("final_idle", 1'b0, 1'b0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
